// File: rtl/core_pkg.sv
// Shared types for the core pipeline: load widths, the ma->wb bundle and the datapath width.
package core_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      LF_LB  = 3'b000,
      LF_LH  = 3'b001,
      LF_LW  = 3'b010,
      LF_LBU = 3'b100,
      LF_LHU = 3'b101
   } load_funct3_e;

   typedef struct packed {
      logic [XLEN-1:0] reg_data;
      logic [XLEN-1:0] mem_data;
      logic [XLEN-1:0] csr_data;
      logic [4:0]      rd;
      logic [11:0]     csr;
      logic            reg_write;
      logic            csr_write;
      logic            mem_read;
      logic [2:0]      mem_funct3;
      logic [1:0]      addr_lo;
   } mw_bundle_t;

   function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
      return {{(XLEN-8){sgn & b[7]}}, b};
   endfunction

   function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
      return {{(XLEN-16){sgn & h[15]}}, h};
   endfunction

endpackage

// File: rtl/core_wb_load_align.sv
// Combinational load-data alignment: picks the byte/half named by the offset and extends it.
module core_wb_load_align
   import core_pkg::*;
(
   input  logic [31:0] w,
   input  logic [1:0]  a,
   input  logic [2:0]  funct3,
   output logic [31:0] aligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'(w >> {a, 3'b000});
      // ma guarantees halfword alignment, so only a[1] matters
      half_sel = a[1] ? w[31:16] : w[15:0];
      aligned  = w;
      case (funct3)
         LF_LB:   aligned = ext8(byte_sel, 1'b1);
         LF_LBU:  aligned = ext8(byte_sel, 1'b0);
         LF_LH:   aligned = ext16(half_sel, 1'b1);
         LF_LHU:  aligned = ext16(half_sel, 1'b0);
         default: aligned = w;
      endcase
   end

endmodule

// File: rtl/core_wb.sv
// Write-back stage: one-entry holding register, load alignment, rf/CSR writes, bypass, instret.
// Define CORE_WB_INSTRET_EN to build the retired-instruction counter; otherwise wb_instret is 0.
module core_wb
   import core_pkg::*;
#(
   parameter int XLEN      = core_pkg::XLEN,
   parameter int INSTRET_W = 64
) (
   input  logic                 clk,
   input  logic                 rest,
   input  logic                 mw_valid,
   output logic                 mw_ready,
   input  logic [XLEN-1:0]      mw_reg_data,
   input  logic [XLEN-1:0]      mw_mem_data,
   input  logic [XLEN-1:0]      mw_csr_data,
   input  logic [4:0]           mw_rd,
   input  logic [11:0]          mw_csr,
   input  logic                 mw_reg_write,
   input  logic                 mw_csr_write,
   input  logic                 mw_mem_read,
   input  logic [2:0]           mw_mem_funct3,
   input  logic [1:0]           mw_addr_lo,
   output logic                 rf_we,
   output logic [4:0]           rf_waddr,
   output logic [XLEN-1:0]      rf_wdata,
   output logic                 csr_wvalid,
   input  logic                 csr_wready,
   output logic [11:0]          csr_waddr,
   output logic [XLEN-1:0]      csr_wdata,
   output logic                 wb_fwd_valid,
   output logic [4:0]           wb_fwd_rd,
   output logic [XLEN-1:0]      wb_fwd_data,
   output logic [INSTRET_W-1:0] wb_instret
);

   mw_bundle_t      mw_d;
   mw_bundle_t      mw_q;
   logic            valid_q;
   logic            retire;
   logic            capture;
   logic            rd_live;
   logic [XLEN-1:0] aligned;
   logic [XLEN-1:0] result;

   always_comb begin
      mw_d            = '0;
      mw_d.reg_data   = mw_reg_data;
      mw_d.mem_data   = mw_mem_data;
      mw_d.csr_data   = mw_csr_data;
      mw_d.rd         = mw_rd;
      mw_d.csr        = mw_csr;
      mw_d.reg_write  = mw_reg_write;
      mw_d.csr_write  = mw_csr_write;
      mw_d.mem_read   = mw_mem_read;
      mw_d.mem_funct3 = mw_mem_funct3;
      mw_d.addr_lo    = mw_addr_lo;
   end

   // A CSR write holds the entry until the CSR unit takes it
   assign retire   = valid_q && (!mw_q.csr_write || csr_wready);
   assign mw_ready = !valid_q || retire;
   assign capture  = mw_valid && mw_ready;

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         valid_q <= 1'b0;
         mw_q    <= '0;
      end else if (capture) begin
         valid_q <= 1'b1;
         mw_q    <= mw_d;
      end else if (retire) begin
         valid_q <= 1'b0;
      end
   end

   core_wb_load_align u_load_align (
      .w       (mw_q.mem_data),
      .a       (mw_q.addr_lo),
      .funct3  (mw_q.mem_funct3),
      .aligned (aligned)
   );

   assign result  = mw_q.mem_read ? aligned : mw_q.reg_data;
   assign rd_live = mw_q.reg_write && (mw_q.rd != 5'd0);

   assign rf_we    = retire && rd_live;
   assign rf_waddr = mw_q.rd;
   assign rf_wdata = result;

   assign csr_wvalid = valid_q && mw_q.csr_write;
   assign csr_waddr  = mw_q.csr;
   assign csr_wdata  = mw_q.csr_data;

   // Bypass stays up through a CSR stall so ex sees the pending value
   assign wb_fwd_valid = valid_q && rd_live;
   assign wb_fwd_rd    = mw_q.rd;
   assign wb_fwd_data  = result;

`ifdef CORE_WB_INSTRET_EN
   logic [INSTRET_W-1:0] instret_q;

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         instret_q <= '0;
      end else if (retire) begin
         instret_q <= instret_q + 1'b1;
      end
   end

   assign wb_instret = instret_q;
`else
   assign wb_instret = '0;
`endif

endmodule

// File: tb/tb_core_wb.sv
// Self-checking bench for core_wb: rf writes checked against a scoreboard queue of expected {rd, data}.
module tb_core_wb;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rest = 1'b0;
   logic        mw_valid = 1'b0;
   logic        mw_ready;
   logic [31:0] mw_reg_data = '0, mw_mem_data = '0, mw_csr_data = '0;
   logic [4:0]  mw_rd = '0;
   logic [11:0] mw_csr = '0;
   logic        mw_reg_write = 1'b0, mw_csr_write = 1'b0, mw_mem_read = 1'b0;
   logic [2:0]  mw_mem_funct3 = '0;
   logic [1:0]  mw_addr_lo = '0;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        csr_wvalid;
   logic        csr_wready = 1'b1;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic        wb_fwd_valid;
   logic [4:0]  wb_fwd_rd;
   logic [31:0] wb_fwd_data;
   logic [63:0] wb_instret;

   int total = 0;
   int bad = 0;
   int wr_cnt = 0;
   longint unsigned exp_instret = 0;
   logic [36:0] sb_q[$];

   core_wb #(.XLEN(32), .INSTRET_W(64)) dut (
      .clk(clk), .rest(rest),
      .mw_valid(mw_valid), .mw_ready(mw_ready),
      .mw_reg_data(mw_reg_data), .mw_mem_data(mw_mem_data), .mw_csr_data(mw_csr_data),
      .mw_rd(mw_rd), .mw_csr(mw_csr),
      .mw_reg_write(mw_reg_write), .mw_csr_write(mw_csr_write), .mw_mem_read(mw_mem_read),
      .mw_mem_funct3(mw_mem_funct3), .mw_addr_lo(mw_addr_lo),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .csr_wvalid(csr_wvalid), .csr_wready(csr_wready),
      .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
      .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
      .wb_instret(wb_instret)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] instret_model();
`ifdef CORE_WB_INSTRET_EN
      return exp_instret;
`else
      return 64'd0;
`endif
   endfunction

   // Scoreboard consumer: every rf write must match the oldest expectation
   always @(negedge clk) begin
      if (rest === 1'b1 && rf_we === 1'b1) begin
         logic [36:0] exp;
         total++;
         wr_cnt++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL rf_unexpected: got waddr=%0d wdata=%h, required no write", rf_waddr, rf_wdata);
         end else begin
            exp = sb_q.pop_front();
            if ({rf_waddr, rf_wdata} !== exp) begin
               bad++;
               $display("FAIL rf_write: got waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                        rf_waddr, rf_wdata, exp[36:32], exp[31:0]);
            end
         end
      end
   end

   task automatic set_fields(input logic [31:0] reg_data, input logic [31:0] mem_data,
                             input logic [4:0] rd, input logic reg_write, input logic mem_read,
                             input logic [2:0] f3, input logic [1:0] a, input logic csr_write,
                             input logic [11:0] csr, input logic [31:0] csr_data);
      mw_reg_data = reg_data; mw_mem_data = mem_data; mw_rd = rd;
      mw_reg_write = reg_write; mw_mem_read = mem_read; mw_mem_funct3 = f3;
      mw_addr_lo = a; mw_csr_write = csr_write; mw_csr = csr; mw_csr_data = csr_data;
   endtask

   // Presents the current fields until accepted; enters and leaves at posedge+1
   task automatic send_current();
      int n = 0;
      mw_valid = 1'b1;
      @(negedge clk);
      while (mw_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 20) begin
         bad++;
         $display("FAIL send_timeout: got mw_ready=%b, required 1 within 20 cycles", mw_ready);
      end
      @(posedge clk); #1;
      mw_valid = 1'b0;
      exp_instret++;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      rest = 1'b0;
      #12;
      total++;
      if ({rf_we, csr_wvalid, wb_fwd_valid, rf_waddr, rf_wdata, csr_waddr, csr_wdata, wb_fwd_rd, wb_fwd_data} !== '0
          || wb_instret !== 64'd0 || mw_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_outputs: got rf_we=%b csr_wvalid=%b fwd=%b instret=%0d mw_ready=%b, required zeros and mw_ready=1",
                  rf_we, csr_wvalid, wb_fwd_valid, wb_instret, mw_ready);
      end
      @(negedge clk);
      rest = 1'b1;
      exp_instret = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_loads();
      logic [2:0]  f3s  [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001, 3'b011};
      logic [31:0] ws   [8] = '{32'h807766F0, 32'h807766F0, 32'h80001234, 32'h80001234,
                               32'hDEADBEEF, 32'h807766F0, 32'h80001234, 32'hCAFEF00D};
      logic [1:0]  as   [8] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd3, 2'd2};
      logic [31:0] exps [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000, 32'h00001234,
                               32'hDEADBEEF, 32'h00000066, 32'hFFFF8000, 32'hCAFEF00D};
      for (int i = 0; i < 8; i++) begin
         set_fields(32'h5555AAAA, ws[i], 5'(i + 1), 1'b1, 1'b1, f3s[i], as[i], 1'b0, 12'h0, 32'h0);
         sb_q.push_back({5'(i + 1), exps[i]});
         send_current();
      end
      set_fields(32'h12345678, 32'hFFFFFFFF, 5'd9, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 12'h0, 32'h0);
      sb_q.push_back({5'd9, 32'h12345678});
      send_current();
      idle(1);
   endtask

   task automatic test_x0();
      set_fields(32'd5, 32'h0, 5'd0, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 12'h0, 32'h0);
      send_current();
      @(negedge clk);
      total++;
      if (rf_we !== 1'b0 || wb_fwd_valid !== 1'b0) begin
         bad++;
         $display("FAIL x0_write: got rf_we=%b fwd_valid=%b, required 0 0", rf_we, wb_fwd_valid);
      end
      @(posedge clk); #1;
      total++;
      if (wb_instret !== instret_model()) begin
         bad++;
         $display("FAIL x0_instret: got %0d, required %0d", wb_instret, instret_model());
      end
   endtask

   task automatic test_csr_stall();
      csr_wready = 1'b0;
      set_fields(32'h1800, 32'h0, 5'd5, 1'b1, 1'b0, 3'b000, 2'd0, 1'b1, 12'h300, 32'h8);
      sb_q.push_back({5'd5, 32'h1800});
      send_current();
      set_fields(32'h66, 32'h0, 5'd6, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 12'h0, 32'h0);
      sb_q.push_back({5'd6, 32'h66});
      mw_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (csr_wvalid !== 1'b1 || csr_waddr !== 12'h300 || csr_wdata !== 32'h8
             || mw_ready !== 1'b0 || rf_we !== 1'b0 || wb_fwd_valid !== 1'b1 || wb_fwd_rd !== 5'd5
             || wb_fwd_data !== 32'h1800) begin
            bad++;
            $display("FAIL csr_stall_c%0d: got wvalid=%b waddr=%h wdata=%h ready=%b rf_we=%b fwd=%b/%0d/%h, required 1 300 8 0 0 1/5/1800",
                     c, csr_wvalid, csr_waddr, csr_wdata, mw_ready, rf_we, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
         end
         @(posedge clk); #1;
      end
      csr_wready = 1'b1;
      @(negedge clk);
      total++;
      if (rf_we !== 1'b1 || mw_ready !== 1'b1) begin
         bad++;
         $display("FAIL csr_release: got rf_we=%b mw_ready=%b, required 1 1", rf_we, mw_ready);
      end
      @(posedge clk); #1;
      mw_valid = 1'b0;
      exp_instret++;
      @(negedge clk);
      total++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd6) begin
         bad++;
         $display("FAIL csr_next_capture: got rf_we=%b waddr=%0d, required 1 6", rf_we, rf_waddr);
      end
      @(posedge clk); #1;
      idle(1);
      total++;
      if (wb_instret !== instret_model()) begin
         bad++;
         $display("FAIL csr_instret: got %0d, required %0d", wb_instret, instret_model());
      end
   endtask

   task automatic test_back_to_back();
      int start;
      rest = 1'b0;
      #2;
      rest = 1'b1;
      exp_instret = 0;
      @(posedge clk); #1;
      start = wr_cnt;
      mw_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_fields(32'h100 + 32'(i), 32'h0, 5'(10 + i), 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 12'h0, 32'h0);
         sb_q.push_back({5'(10 + i), 32'h100 + 32'(i)});
         @(negedge clk);
         total++;
         if (mw_ready !== 1'b1 || (i > 0 && rf_we !== 1'b1)) begin
            bad++;
            $display("FAIL b2b_bubble_%0d: got mw_ready=%b rf_we=%b, required 1 1", i, mw_ready, rf_we);
         end
         @(posedge clk); #1;
         exp_instret++;
      end
      mw_valid = 1'b0;
      idle(2);
      total++;
      if (wr_cnt - start !== 10 || wb_instret !== instret_model()) begin
         bad++;
         $display("FAIL b2b_count: got writes=%0d instret=%0d, required 10 %0d",
                  wr_cnt - start, wb_instret, instret_model());
      end
   endtask

   task automatic test_reset_mid_stall();
      csr_wready = 1'b0;
      set_fields(32'h77, 32'h0, 5'd7, 1'b1, 1'b0, 3'b000, 2'd0, 1'b1, 12'h341, 32'hAB);
      send_current();
      @(negedge clk);
      total++;
      if (csr_wvalid !== 1'b1) begin
         bad++;
         $display("FAIL rst_stall_pre: got csr_wvalid=%b, required 1", csr_wvalid);
      end
      #1 rest = 1'b0;
      #1;
      exp_instret = 0;
      total++;
      if (csr_wvalid !== 1'b0 || rf_we !== 1'b0 || mw_ready !== 1'b1 || wb_instret !== 64'd0) begin
         bad++;
         $display("FAIL rst_stall: got csr_wvalid=%b rf_we=%b mw_ready=%b instret=%0d, required 0 0 1 0",
                  csr_wvalid, rf_we, mw_ready, wb_instret);
      end
      @(posedge clk); #1;
      rest = 1'b1;
      idle(2);
      csr_wready = 1'b1;
      idle(2);
      total++;
      if (csr_wvalid !== 1'b0 || wb_instret !== 64'd0) begin
         bad++;
         $display("FAIL rst_stall_after: got csr_wvalid=%b instret=%0d, required 0 0", csr_wvalid, wb_instret);
      end
   endtask

   initial begin
      test_reset();
      test_loads();
      test_x0();
      test_csr_stall();
      test_back_to_back();
      test_reset_mid_stall();
      total++;
      if (sb_q.size() !== 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d pending writes, required 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
